// File: rtl/pid_mc_pkg.sv
// pid_mc_pkg: shared types and width helpers for the pid_mc controller.
// Holds the FSM state enum, accumulator width and channel-index width.
package pid_mc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MUL0,
        MUL1,
        MUL2,
        SAT,
        OUT
    } state_t;

    // Wide enough that u_prev<<<FRAC plus three gain*error terms
    // can never overflow.
    function automatic int acc_w(input int w, input int gw, input int frac);
        return w + gw + frac + 4;
    endfunction

    function automatic int ch_w(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/pid_mc_sat.sv
// pid_mc_sat: combinational round-half-up, shift by FRAC and clamp.
// Ports: i_acc (accumulator), i_min/i_max (limits), o_u (result), o_sat (clamped).
module pid_mc_sat
    import pid_mc_pkg::*;
#(
    parameter int W    = 16,
    parameter int GW   = 16,
    parameter int FRAC = 8
) (
    input  logic signed [acc_w(W, GW, FRAC)-1:0] i_acc,
    input  logic signed [W-1:0]                  i_min,
    input  logic signed [W-1:0]                  i_max,
    output logic signed [W-1:0]                  o_u,
    output logic                                 o_sat
);

    localparam int AW = acc_w(W, GW, FRAC);
    localparam logic signed [AW-1:0] HALF = AW'(1) << (FRAC - 1);

    logic signed [AW-1:0] w_rnd;
    logic signed [AW-1:0] w_shr;
    logic signed [AW-1:0] w_min;
    logic signed [AW-1:0] w_max;

    assign w_rnd = i_acc + HALF;
    assign w_shr = w_rnd >>> FRAC;
    assign w_min = {{(AW - W){i_min[W-1]}}, i_min};
    assign w_max = {{(AW - W){i_max[W-1]}}, i_max};

    always_comb begin
        o_u   = w_shr[W-1:0];
        o_sat = 1'b0;
        if (w_shr < w_min) begin
            o_u   = i_min;
            o_sat = 1'b1;
        end else if (w_shr > w_max) begin
            o_u   = i_max;
            o_sat = 1'b1;
        end
    end

endmodule

// File: rtl/pid_mc.sv
// pid_mc: multi-channel velocity-form PID, one shared multiplier.
// u[n] = u[n-1] + k1*e[n] + k2*e[n-1] + k3*e[n-2], clamped with anti-windup.
// Ports: clk/reset (sync, active-high); in_valid/in_ready/in_ch/in_e sample in;
// kp/ki/kd gains and u_min/u_max limits latched at accept;
// out_valid/out_ready/out_ch/out_u/out_sat result; err_ch sticky bad-channel flag.
// Macro PID_DERIV_EN enables the derivative term (e2 storage and MUL2 state).
module pid_mc
    import pid_mc_pkg::*;
#(
    parameter int W    = 16,
    parameter int CH   = 4,
    parameter int GW   = 16,
    parameter int FRAC = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ch_w(CH)-1:0]    in_ch,
    input  logic signed [W-1:0]    in_e,
    input  logic signed [GW-1:0]   kp,
    input  logic signed [GW-1:0]   ki,
    input  logic signed [GW-1:0]   kd,
    input  logic signed [W-1:0]    u_min,
    input  logic signed [W-1:0]    u_max,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ch_w(CH)-1:0]    out_ch,
    output logic signed [W-1:0]    out_u,
    output logic                   out_sat,
    output logic                   err_ch
);

    localparam int CW = ch_w(CH);
    localparam int AW = acc_w(W, GW, FRAC);
    localparam int KW = GW + 2;
    localparam int PW = KW + W;
    localparam logic [CW:0] CHV = (CW + 1)'(CH);

    state_t               r_state;
    logic [CW-1:0]        r_ch;
    logic signed [W-1:0]  r_e;
    logic signed [W-1:0]  r_min;
    logic signed [W-1:0]  r_max;
    logic signed [KW-1:0] r_k1;
    logic signed [KW-1:0] r_k2;
    logic signed [AW-1:0] r_acc;
    logic signed [W-1:0]  r_uprev [CH];
    logic signed [W-1:0]  r_e1    [CH];
`ifdef PID_DERIV_EN
    logic signed [KW-1:0] r_k3;
    logic signed [W-1:0]  r_e2    [CH];
`endif

    logic signed [KW-1:0] w_kp;
    logic signed [KW-1:0] w_ki;
    logic signed [KW-1:0] w_kd;
    logic signed [KW-1:0] w_k1;
    logic signed [KW-1:0] w_k2;
    logic signed [KW-1:0] w_k;
    logic signed [W-1:0]  w_e;
    logic signed [PW-1:0] w_p;
    logic signed [AW-1:0] w_pe;
    logic signed [AW-1:0] w_up;
    logic signed [W-1:0]  w_u;
    logic                 w_sat;

    assign w_kp = {{2{kp[GW-1]}}, kp};
    assign w_ki = {{2{ki[GW-1]}}, ki};
`ifdef PID_DERIV_EN
    assign w_kd = {{2{kd[GW-1]}}, kd};
`else
    logic w_unused_kd;
    assign w_kd        = '0;
    assign w_unused_kd = ^kd;
`endif
    assign w_k1 = w_kp + w_ki + w_kd;
    assign w_k2 = -w_kp - (w_kd <<< 1);

    // The single multiplier: operand pair chosen by the current step.
    always_comb begin
        w_k = r_k1;
        w_e = r_e;
        case (r_state)
            MUL1: begin
                w_k = r_k2;
                w_e = r_e1[r_ch];
            end
`ifdef PID_DERIV_EN
            MUL2: begin
                w_k = r_k3;
                w_e = r_e2[r_ch];
            end
`endif
            default: ;
        endcase
    end

    assign w_p  = w_k * w_e;
    assign w_pe = {{(AW - PW){w_p[PW-1]}}, w_p};
    assign w_up = {{(AW - W){r_uprev[r_ch][W-1]}}, r_uprev[r_ch]} <<< FRAC;

    pid_mc_sat #(
        .W    (W),
        .GW   (GW),
        .FRAC (FRAC)
    ) u_sat (
        .i_acc (r_acc),
        .i_min (r_min),
        .i_max (r_max),
        .o_u   (w_u),
        .o_sat (w_sat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_u     <= '0;
            out_sat   <= 1'b0;
            err_ch    <= 1'b0;
            r_ch      <= '0;
            r_e       <= '0;
            r_min     <= '0;
            r_max     <= '0;
            r_k1      <= '0;
            r_k2      <= '0;
            r_acc     <= '0;
`ifdef PID_DERIV_EN
            r_k3      <= '0;
`endif
            for (int i = 0; i < CH; i++) begin
                r_uprev[i] <= '0;
                r_e1[i]    <= '0;
`ifdef PID_DERIV_EN
                r_e2[i]    <= '0;
`endif
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        // A bad channel is consumed in place; nothing runs.
                        if ({1'b0, in_ch} >= CHV) begin
                            err_ch <= 1'b1;
                        end else begin
                            r_ch     <= in_ch;
                            r_e      <= in_e;
                            r_min    <= u_min;
                            r_max    <= u_max;
                            r_k1     <= w_k1;
                            r_k2     <= w_k2;
`ifdef PID_DERIV_EN
                            r_k3     <= w_kd;
`endif
                            in_ready <= 1'b0;
                            r_state  <= MUL0;
                        end
                    end
                end
                MUL0: begin
                    r_acc   <= w_up + w_pe;
                    r_state <= MUL1;
                end
                MUL1: begin
                    r_acc   <= r_acc + w_pe;
`ifdef PID_DERIV_EN
                    r_state <= MUL2;
`else
                    r_state <= SAT;
`endif
                end
`ifdef PID_DERIV_EN
                MUL2: begin
                    r_acc   <= r_acc + w_pe;
                    r_state <= SAT;
                end
`endif
                SAT: begin
                    out_valid      <= 1'b1;
                    out_ch         <= r_ch;
                    out_u          <= w_u;
                    out_sat        <= w_sat;
                    // Clamped value feeds back, so no windup.
                    r_uprev[r_ch]  <= w_u;
                    r_e1[r_ch]     <= r_e;
`ifdef PID_DERIV_EN
                    r_e2[r_ch]     <= r_e1[r_ch];
`endif
                    r_state        <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    in_ready <= 1'b1;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pid_mc.sv
// tb_pid_mc: directed self-checking bench for pid_mc (CH=5 so in_ch=5 is invalid).
// Expected values are hand-computed for FRAC=8 gains.
module tb_pid_mc;

    localparam int W  = 16;
    localparam int CH = 5;
    localparam int GW = 16;
    localparam int CW = 3;
`ifdef PID_DERIV_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic                 clk;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [CW-1:0]        in_ch;
    logic signed [W-1:0]  in_e;
    logic signed [GW-1:0] kp;
    logic signed [GW-1:0] ki;
    logic signed [GW-1:0] kd;
    logic signed [W-1:0]  u_min;
    logic signed [W-1:0]  u_max;
    logic                 out_valid;
    logic                 out_ready;
    logic [CW-1:0]        out_ch;
    logic signed [W-1:0]  out_u;
    logic                 out_sat;
    logic                 err_ch;

    int errors = 0;
    int checks = 0;

    pid_mc #(
        .W    (W),
        .CH   (CH),
        .GW   (GW),
        .FRAC (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_e      (in_e),
        .kp        (kp),
        .ki        (ki),
        .kd        (kd),
        .u_min     (u_min),
        .u_max     (u_max),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_u     (out_u),
        .out_sat   (out_sat),
        .err_ch    (err_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One sample through the block; optional 3-cycle output stall.
    task automatic txn(input string tag, input int ch, input int e,
                       input int exp_u, input int exp_sat, input bit hold);
        int cyc;
        int seen;
        @(negedge clk);
        chk({tag, ".rdy"}, in_ready, 1);
        in_valid = 1'b1;
        in_ch    = ch[CW-1:0];
        in_e     = e[W-1:0];
        if (hold) out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_ch    = 3'd4;
        in_e     = 16'sh7fff;
        cyc      = 1;
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".lat"}, cyc, LAT);
        chk({tag, ".u"}, out_u, exp_u);
        chk({tag, ".sat"}, out_sat, exp_sat);
        chk({tag, ".ch"}, out_ch, ch);
        if (hold) begin
            in_valid = 1'b1;
            in_ch    = 3'd1;
            in_e     = 16'sd5;
            repeat (2) begin
                @(negedge clk);
                chk({tag, ".hold_v"}, out_valid, 1);
                chk({tag, ".hold_u"}, out_u, exp_u);
                chk({tag, ".hold_ch"}, out_ch, ch);
                chk({tag, ".hold_rdy"}, in_ready, 0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk({tag, ".post_rdy"}, in_ready, 1);
        chk({tag, ".post_v"}, out_valid, 0);
        if (hold) begin
            seen = 0;
            repeat (LAT + 2) begin
                @(negedge clk);
                if (out_valid === 1'b1) seen++;
            end
            chk({tag, ".no_accept"}, seen, 0);
        end
    endtask

    initial begin
        int seen;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_ch     = '0;
        in_e      = '0;
        out_ready = 1'b1;
        kp        = 16'sh0080;
        ki        = 16'sh0040;
        kd        = 16'sh0000;
        u_min     = -16'sd30000;
        u_max     = 16'sd30000;
        repeat (3) @(negedge clk);
        chk("rst.in_ready", in_ready, 1);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_ch", out_ch, 0);
        chk("rst.out_u", out_u, 0);
        chk("rst.out_sat", out_sat, 0);
        chk("rst.err_ch", err_ch, 0);
        reset = 1'b0;

        // PI step and channel isolation
        txn("pi0a", 0, 100, 75, 0, 1'b0);
        txn("pi0b", 0, 100, 100, 0, 1'b0);
        txn("pi1a", 1, 100, 75, 0, 1'b0);
        txn("pi0c", 0, 0, 50, 0, 1'b1);
        txn("pi1b", 1, 100, 100, 0, 1'b0);

        // Saturation with anti-windup
        u_max = 16'sd90;
        txn("sat_a", 2, 100, 75, 0, 1'b0);
        txn("sat_b", 2, 100, 90, 1, 1'b0);
        txn("sat_c", 2, 0, 40, 0, 1'b0);
        u_max = 16'sd30000;

        // Rounding half-up
        kp = 16'sh0001;
        ki = 16'sh0000;
        txn("rnd_p", 3, 128, 1, 0, 1'b0);
        txn("rnd_n", 4, -128, 0, 0, 1'b0);

        // Invalid channel
        @(negedge clk);
        in_valid = 1'b1;
        in_ch    = 3'd5;
        in_e     = 16'sd100;
        @(negedge clk);
        in_valid = 1'b0;
        chk("badch.err", err_ch, 1);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        chk("badch.no_out", seen, 0);
        chk("badch.rdy", in_ready, 1);

        // Reset while in MUL1
        kp = 16'sh0080;
        ki = 16'sh0040;
        @(negedge clk);
        in_valid = 1'b1;
        in_ch    = 3'd0;
        in_e     = 16'sd100;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mrst.out_valid", out_valid, 0);
        chk("mrst.in_ready", in_ready, 1);
        chk("mrst.err_ch", err_ch, 0);
        chk("mrst.out_u", out_u, 0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        chk("mrst.no_out", seen, 0);
        txn("mrst.ch0", 0, 100, 75, 0, 1'b0);

        // Derivative path
        kp = 16'sh0000;
        ki = 16'sh0000;
        kd = 16'sh0100;
`ifdef PID_DERIV_EN
        txn("der_a", 1, 10, 10, 0, 1'b0);
        txn("der_b", 1, 10, 0, 0, 1'b0);
        txn("der_c", 1, 0, -10, 0, 1'b0);
`else
        txn("der_a", 1, 10, 0, 0, 1'b0);
        txn("der_b", 1, 10, 0, 0, 1'b0);
        txn("der_c", 1, 0, 0, 0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pid_mc.md
Name: pid_mc

Overview:
- Multi-channel, fixed-point, velocity-form PID controller: u[n] = u[n-1] + k1*e[n] + k2*e[n-1] + k3*e[n-2].
- k1 = kp+ki+kd, k2 = -kp-2*kd, k3 = kd.
- Time-shares one multiplier across CH motor channels, with valid/ready handshakes on input and output.
- Adds runtime gains, output clamping with anti-windup, rounding and backpressure.
- Sits between the per-motor error computation and the PWM command stage.

Parameters:
- W, 16, signed error/output width in bits.
- CH, 4, number of independent channels (>=1).
- GW, 16, signed gain width in bits.
- FRAC, 8, fractional bits in gains (Q(GW-FRAC).FRAC); FRAC>=1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  error sample valid
- in_ready  out  1  block can accept a sample
- in_ch  in  $clog2(CH) (min 1)  channel index of sample
- in_e  in  W  signed error e[n]
- kp, ki, kd  in  GW each  signed gains, sampled at accept
- u_min, u_max  in  W each  signed clamp limits; u_min<=u_max required
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_ch  out  $clog2(CH)  channel of result
- out_u  out  W  signed control output u[n]
- out_sat  out  1  result was clamped
- err_ch  out  1  sticky: sample with in_ch>=CH was seen

Behaviour:
- Reset: in_ready=1, out_valid=0, out_ch=0, out_u=0, out_sat=0, err_ch=0. All per-channel u_prev, e1 and e2 are 0. FSM goes to IDLE.
- Accept: a sample is accepted when in_valid&&in_ready, which is only possible in IDLE. in_ch, in_e, gains and limits are latched on accept; later port changes do not affect the sample in flight.
- FSM sequence: IDLE -> MUL0 (acc = (u_prev<<<FRAC) + k1*e) -> MUL1 (acc += k2*e1) -> MUL2 (acc += k3*e2) -> SAT -> OUT -> IDLE.
- Latency: accept in cycle t gives out_valid=1 in cycle t+5.
- Gain derivation: k1, k2 and k3 are computed in GW+2 bits. Accumulator width is W+GW+FRAC+4; no intermediate overflow is permitted.
- SAT step:
  - Round half-up: add 1<<<(FRAC-1), then arithmetic shift right by FRAC.
  - Clamp to [u_min,u_max] and set out_sat if clamped.
  - Write back channel state: u_prev <= clamped value (anti-windup), e2 <= e1, e1 <= e.
- OUT: out_valid, out_ch, out_u and out_sat are held stable while out_ready=0. Leave OUT on out_valid&&out_ready. in_ready stays 0 throughout.
- Single-sample throughput: in_ready is re-asserted the cycle after the output handshake. Minimum spacing between accepts is 6 cycles.
- Channel isolation: processing channel i never modifies the state of channel j.
- Invalid channel (in_ch>=CH): the sample is accepted, no state is updated, no output is produced, err_ch is set (cleared only by reset), and the FSM returns to IDLE the next cycle.
- Reset mid-operation: the in-flight sample is discarded, all state is cleared, and no output is produced.
- Equal limits (u_min==u_max): out_u is the limit. out_sat=1 unless the unclamped value equals the limit.

Optional Feature:
- Macro: PID_DERIV_EN.
- Defined: derivative path as above, with per-channel e2 storage and the MUL2 state. Latency is 5 cycles.
- Undefined: kd is ignored (treated as 0), e2 storage and MUL2 are removed, and SAT follows MUL1. Latency is 4 cycles; minimum accept spacing is 5 cycles.

Decomposition:
- Package pid_mc_pkg holds:
  - the FSM state enum (IDLE, MUL0, MUL1, MUL2, SAT, OUT);
  - an accumulator-width function of W, GW and FRAC;
  - a channel-index-width function (min 1).
- Sub-module pid_mc_sat: purely combinational round + shift + clamp, producing u and the sat flag. It is instantiated once.

Test Plan:
- Proportional-integral step, FRAC=8, kp=0x0080, ki=0x0040, kd=0, limits ±30000. Ch0 e=100 -> u=75. Ch0 e=100 again -> u=100 (75+75-50). out_valid exactly 5 cycles after accept.
- Channel isolation: after the above, ch1 e=100 -> u=75. Ch0 e=0 -> u=50 (100+0-50); ch1 state unaffected.
- Saturation/anti-windup: u_max=90, same gains, ch2 e=100 twice -> 75, then 90 with out_sat=1. Then e=0 -> 40 (90-50), out_sat=0.
- Backpressure: out_ready=0 for 3 cycles at OUT -> out_u/out_ch held, in_ready=0, an offered in_valid is not accepted. Release -> handshake, in_ready=1 next cycle.
- Rounding: kp=0x0001, ki=kd=0, e=128 -> u=1. Then e=-128 on a fresh channel -> u=0 (round half-up of -0.5).
- Derivative (PID_DERIV_EN), kp=ki=0, kd=0x0100, e sequence 10, 10, 0 -> u = 10, 0, -10. Without the macro, same stimulus -> u = 0, 0, 0, with 4-cycle latency.
- Boundary: in_ch=CH -> err_ch=1, no out_valid. Assert reset in MUL1 -> no output, next ch0 e=100 with the first test's gains -> u=75.
